nmea_gpgll_tx: RTL and testbench

Builds an NMEA-0183 GLL position sentence from latched BCD position, UTC and fix-status fields, and streams it out one ASCII byte at a time to the UART transmitter. It is the outbound counterpart of the NMEA receive/parse path. It produces the same sentence layout the parser consumes, for example `$GPGLL,1234.56,N,9876.54,E,122519,A*10\r\n`. The hex checksum is computed on the fly.

---
 rtl/nmea_pkg.sv | 46 ++++
 rtl/nmea_hex_ascii.sv | 20 ++
 rtl/nmea_gpgll_tx.sv | 193 +++++++++++++++++++
 tb/tb_nmea_gpgll_tx.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nmea_pkg
// Description : Shared definitions for the NMEA-0183 transmit/parse path:
//               ASCII character constants, GLL body length, the GLL
//               transmitter state encoding and a BCD digit to ASCII helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nmea_pkg;

  localparam logic [7:0] c_dollar = 8'h24;  // '$'
  localparam logic [7:0] c_star   = 8'h2A;  // '*'
  localparam logic [7:0] c_comma  = 8'h2C;  // ','
  localparam logic [7:0] c_dot    = 8'h2E;  // '.'
  localparam logic [7:0] c_cr     = 8'h0D;
  localparam logic [7:0] c_lf     = 8'h0A;
  localparam logic [7:0] c_a      = 8'h41;  // 'A'
  localparam logic [7:0] c_v      = 8'h56;  // 'V'
  localparam logic [7:0] c_n      = 8'h4E;  // 'N'
  localparam logic [7:0] c_s      = 8'h53;  // 'S'
  localparam logic [7:0] c_e      = 8'h45;  // 'E'
  localparam logic [7:0] c_w      = 8'h57;  // 'W'
  localparam logic [7:0] c_g      = 8'h47;  // 'G'
  localparam logic [7:0] c_l      = 8'h4C;  // 'L'
  localparam logic [7:0] c_zero   = 8'h30;  // '0'

  // Bytes from '$' up to and including the A/V letter
  localparam int GLL_BODY_LEN = 35;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BODY  = 3'd1,
    S_STAR  = 3'd2,
    S_CK_HI = 3'd3,
    S_CK_LO = 3'd4,
    S_CR    = 3'd5,
    S_LF    = 3'd6
  } gll_state_t;

  // Out-of-range BCD digits are sent as '0'; the caller flags them.
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? c_zero : (c_zero + {4'h0, d});
  endfunction

endpackage : nmea_pkg
`default_nettype wire

// File: rtl/nmea_hex_ascii.sv
`default_nettype none
// ============================================================================
// Module      : nmea_hex_ascii
// Description : Combinational nibble to uppercase ASCII hex converter.
//               i_nibble : 4-bit value
//               o_ascii  : '0'..'9' or 'A'..'F'
// Revision    : 1.0 - initial release
// ============================================================================
module nmea_hex_ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble > 4'd9) o_ascii = 8'h37 + {4'h0, i_nibble};
    else                 o_ascii = 8'h30 + {4'h0, i_nibble};
  end

endmodule : nmea_hex_ascii
`default_nettype wire

// File: rtl/nmea_gpgll_tx.sv
`default_nettype none
// ============================================================================
// Module      : nmea_gpgll_tx
// Description : Builds an NMEA-0183 GLL sentence from latched BCD position,
//               UTC and fix status, streaming it one ASCII byte at a time
//               over a valid/ready handshake with an on-the-fly checksum.
// Ports       : clk, rst (async, active low)
//               i_start                     - request one sentence (IDLE only)
//               i_lat_bcd/i_lat_n           - latitude DDMM.mm + N/S
//               i_lon_bcd/i_lon_e           - longitude DDMM.mm + E/W
//               i_utc_bcd/i_fix_valid       - UTC hhmmss + A/V
//               o_tx_byte/o_tx_dv/i_tx_ready- byte stream to UART TX
//               o_busy, o_done, o_fmt_err   - status
// Revision    : 1.0 - initial release
// ============================================================================
module nmea_gpgll_tx
  import nmea_pkg::*;
#(
  parameter logic [15:0] TALKER_ID = 16'h4750
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [23:0] i_lat_bcd,
  input  logic        i_lat_n,
  input  logic [23:0] i_lon_bcd,
  input  logic        i_lon_e,
  input  logic [23:0] i_utc_bcd,
  input  logic        i_fix_valid,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_dv,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fmt_err
);

  gll_state_t  r_state;
  logic [5:0]  r_idx;
  logic [7:0]  r_csum;
  logic [23:0] r_lat;
  logic [23:0] r_lon;
  logic [23:0] r_utc;
  logic        r_lat_n;
  logic        r_lon_e;
  logic        r_valid;

  logic        w_xfer;
  logic [5:0]  w_idx_next;
  logic [7:0]  w_body_byte;
  logic        w_body_bad;
  logic [3:0]  w_digit;
  logic        w_is_digit;
  logic [7:0]  w_ck_hi;
  logic [7:0]  w_ck_lo;

  assign w_xfer     = o_tx_dv && i_tx_ready;
  assign w_idx_next = r_idx + 6'd1;

  nmea_hex_ascii u_hex_hi (.i_nibble(r_csum[7:4]), .o_ascii(w_ck_hi));
  nmea_hex_ascii u_hex_lo (.i_nibble(r_csum[3:0]), .o_ascii(w_ck_lo));

  // Body-byte mux: the byte to present after the current one is accepted.
  always_comb begin
    w_body_byte = c_comma;
    w_digit     = 4'h0;
    w_is_digit  = 1'b0;
    case (w_idx_next)
      6'd0:  w_body_byte = c_dollar;
      6'd1:  w_body_byte = TALKER_ID[15:8];
      6'd2:  w_body_byte = TALKER_ID[7:0];
      6'd3:  w_body_byte = c_g;
      6'd4:  w_body_byte = c_l;
      6'd5:  w_body_byte = c_l;
      6'd7:  begin w_is_digit = 1'b1; w_digit = r_lat[23:20]; end
      6'd8:  begin w_is_digit = 1'b1; w_digit = r_lat[19:16]; end
      6'd9:  begin w_is_digit = 1'b1; w_digit = r_lat[15:12]; end
      6'd10: begin w_is_digit = 1'b1; w_digit = r_lat[11:8];  end
      6'd11: w_body_byte = c_dot;
      6'd12: begin w_is_digit = 1'b1; w_digit = r_lat[7:4];   end
      6'd13: begin w_is_digit = 1'b1; w_digit = r_lat[3:0];   end
      6'd15: w_body_byte = r_lat_n ? c_n : c_s;
      6'd17: begin w_is_digit = 1'b1; w_digit = r_lon[23:20]; end
      6'd18: begin w_is_digit = 1'b1; w_digit = r_lon[19:16]; end
      6'd19: begin w_is_digit = 1'b1; w_digit = r_lon[15:12]; end
      6'd20: begin w_is_digit = 1'b1; w_digit = r_lon[11:8];  end
      6'd21: w_body_byte = c_dot;
      6'd22: begin w_is_digit = 1'b1; w_digit = r_lon[7:4];   end
      6'd23: begin w_is_digit = 1'b1; w_digit = r_lon[3:0];   end
      6'd25: w_body_byte = r_lon_e ? c_e : c_w;
      6'd27: begin w_is_digit = 1'b1; w_digit = r_utc[23:20]; end
      6'd28: begin w_is_digit = 1'b1; w_digit = r_utc[19:16]; end
      6'd29: begin w_is_digit = 1'b1; w_digit = r_utc[15:12]; end
      6'd30: begin w_is_digit = 1'b1; w_digit = r_utc[11:8];  end
      6'd31: begin w_is_digit = 1'b1; w_digit = r_utc[7:4];   end
      6'd32: begin w_is_digit = 1'b1; w_digit = r_utc[3:0];   end
      6'd34: w_body_byte = r_valid ? c_a : c_v;
      default: w_body_byte = c_comma;
    endcase
    if (w_is_digit) w_body_byte = bcd_to_ascii(w_digit);
    w_body_bad = w_is_digit && (w_digit > 4'd9);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 6'd0;
      r_csum    <= 8'h00;
      r_lat     <= 24'h0;
      r_lon     <= 24'h0;
      r_utc     <= 24'h0;
      r_lat_n   <= 1'b0;
      r_lon_e   <= 1'b0;
      r_valid   <= 1'b0;
      o_tx_byte <= 8'h00;
      o_tx_dv   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_fmt_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_lat     <= i_lat_bcd;
            r_lon     <= i_lon_bcd;
            r_utc     <= i_utc_bcd;
            r_lat_n   <= i_lat_n;
            r_lon_e   <= i_lon_e;
            r_valid   <= i_fix_valid;
            r_csum    <= 8'h00;
            r_idx     <= 6'd0;
            o_fmt_err <= 1'b0;
            o_tx_byte <= c_dollar;
            o_tx_dv   <= 1'b1;
            o_busy    <= 1'b1;
            r_state   <= S_BODY;
          end
        end
        S_BODY: begin
          if (w_xfer) begin
            // '$' at index 0 is outside the checksum span
            if (r_idx != 6'd0) r_csum <= r_csum ^ o_tx_byte;
            if (r_idx == 6'(GLL_BODY_LEN - 1)) begin
              o_tx_byte <= c_star;
              r_state   <= S_STAR;
            end else begin
              r_idx     <= w_idx_next;
              o_tx_byte <= w_body_byte;
              if (w_body_bad) o_fmt_err <= 1'b1;
            end
          end
        end
        S_STAR: begin
          if (w_xfer) begin
            o_tx_byte <= w_ck_hi;
            r_state   <= S_CK_HI;
          end
        end
        S_CK_HI: begin
          if (w_xfer) begin
            o_tx_byte <= w_ck_lo;
            r_state   <= S_CK_LO;
          end
        end
        S_CK_LO: begin
          if (w_xfer) begin
            o_tx_byte <= c_cr;
            r_state   <= S_CR;
          end
        end
        S_CR: begin
          if (w_xfer) begin
            o_tx_byte <= c_lf;
            r_state   <= S_LF;
          end
        end
        S_LF: begin
          if (w_xfer) begin
            o_tx_byte <= 8'h00;
            o_tx_dv   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule : nmea_gpgll_tx
`default_nettype wire

// File: tb/tb_nmea_gpgll_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_nmea_gpgll_tx
// Description : Self-checking bench for nmea_gpgll_tx. Expected sentences are
//               built by a bench-side model into a scoreboard queue and popped
//               as bytes are transferred.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nmea_gpgll_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [23:0] i_lat_bcd = 24'h0;
  logic        i_lat_n = 1'b0;
  logic [23:0] i_lon_bcd = 24'h0;
  logic        i_lon_e = 1'b0;
  logic [23:0] i_utc_bcd = 24'h0;
  logic        i_fix_valid = 1'b0;
  logic        i_tx_ready = 1'b0;
  logic [7:0]  o_tx_byte;
  logic        o_tx_dv;
  logic        o_busy;
  logic        o_done;
  logic        o_fmt_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  nmea_gpgll_tx #(.TALKER_ID(16'h4750)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_lat_bcd(i_lat_bcd), .i_lat_n(i_lat_n),
    .i_lon_bcd(i_lon_bcd), .i_lon_e(i_lon_e),
    .i_utc_bcd(i_utc_bcd), .i_fix_valid(i_fix_valid),
    .o_tx_byte(o_tx_byte), .o_tx_dv(o_tx_dv), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done), .o_fmt_err(o_fmt_err)
  );

  function automatic logic [7:0] m_digit(input logic [3:0] d);
    return (d > 4'd9) ? 8'h30 : (8'h30 + {4'h0, d});
  endfunction

  function automatic logic [7:0] m_hex(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Reference model: full 40-byte sentence pushed onto the scoreboard.
  task automatic push_model(input logic [23:0] lat, input logic ns,
                            input logic [23:0] lon, input logic ew,
                            input logic [23:0] utc, input logic valid);
    logic [7:0] b[$];
    logic [7:0] ck;
    b.push_back("$"); b.push_back("G"); b.push_back("P");
    b.push_back("G"); b.push_back("L"); b.push_back("L"); b.push_back(",");
    for (int i = 5; i >= 0; i--) begin
      if (i == 1) b.push_back(".");
      b.push_back(m_digit(lat[i*4 +: 4]));
    end
    b.push_back(","); b.push_back(ns ? "N" : "S"); b.push_back(",");
    for (int i = 5; i >= 0; i--) begin
      if (i == 1) b.push_back(".");
      b.push_back(m_digit(lon[i*4 +: 4]));
    end
    b.push_back(","); b.push_back(ew ? "E" : "W"); b.push_back(",");
    for (int i = 5; i >= 0; i--) b.push_back(m_digit(utc[i*4 +: 4]));
    b.push_back(","); b.push_back(valid ? "A" : "V");
    ck = 8'h00;
    for (int i = 1; i < b.size(); i++) ck = ck ^ b[i];
    b.push_back("*"); b.push_back(m_hex(ck[7:4])); b.push_back(m_hex(ck[3:0]));
    b.push_back(8'h0D); b.push_back(8'h0A);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  // Drives fields and a one-cycle start; then scrambles the field inputs.
  task automatic start_sentence(input logic [23:0] lat, input logic ns,
                                input logic [23:0] lon, input logic ew,
                                input logic [23:0] utc, input logic valid);
    @(negedge clk);
    i_lat_bcd = lat; i_lat_n = ns; i_lon_bcd = lon; i_lon_e = ew;
    i_utc_bcd = utc; i_fix_valid = valid; i_start = 1'b1;
    push_model(lat, ns, lon, ew, utc, valid);
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h24 || o_busy !== 1'b1 || o_fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: dv=%b byte=%h busy=%b fmt_err=%b, required dv=1 byte=24 busy=1 fmt_err=0",
               o_tx_dv, o_tx_byte, o_busy, o_fmt_err);
    end
    i_lat_bcd = $urandom; i_lon_bcd = $urandom; i_utc_bcd = $urandom;
    i_lat_n = ~ns; i_lon_e = ~ew; i_fix_valid = ~valid;
  endtask

  // Per-cycle handshake driver and scoreboard monitor. Called at a negedge.
  task automatic run_stream(input bit rand_ready, input int glitch_at,
                            input int stop_after, output int cycles);
    int         n = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    logic [7:0] exp_b;
    cycles = 0;
    got_q.delete();
    forever begin
      if (cycles > 400) begin
        errors++; checks++;
        $display("FAIL stream_timeout: transfers=%0d, required all %0d bytes", n, n + exp_q.size());
        exp_q.delete();
        break;
      end
      i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_start    = (glitch_at >= 0 && n == glitch_at) ? 1'b1 : 1'b0;
      if (prev_stall) begin
        checks++;
        if (o_tx_dv !== 1'b1 || o_tx_byte !== prev_byte) begin
          errors++;
          $display("FAIL stall_hold: dv=%b byte=%h, required dv=1 byte=%h", o_tx_dv, o_tx_byte, prev_byte);
        end
      end
      if (o_done !== 1'b0) begin
        errors++; checks++;
        $display("FAIL done_early: done=%b at transfer %0d, required 0", o_done, n);
      end
      if (o_tx_dv === 1'b1 && i_tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_byte: got %h, required no byte", o_tx_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (o_tx_byte !== exp_b) begin
            errors++;
            $display("FAIL byte[%0d]: got %h, required %h", n, o_tx_byte, exp_b);
          end
        end
        got_q.push_back(o_tx_byte);
        n++;
      end
      prev_stall = (o_tx_dv === 1'b1) && !i_tx_ready;
      prev_byte  = o_tx_byte;
      @(negedge clk);
      cycles++;
      if (stop_after > 0 && n == stop_after) break;
      if (stop_after == 0 && exp_q.size() == 0) break;
    end
    i_start = 1'b0;
    if (stop_after == 0) begin
      checks++;
      if (o_done !== 1'b1 || o_busy !== 1'b0 || o_tx_dv !== 1'b0) begin
        errors++;
        $display("FAIL sentence_end: done=%b busy=%b dv=%b, required done=1 busy=0 dv=0",
                 o_done, o_busy, o_tx_dv);
      end
    end
  endtask

  task automatic check_done_drop();
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_tx_dv !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b dv=%b, required 0 0", o_done, o_tx_dv);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_tx_byte !== 8'h00 || o_tx_dv !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: byte=%h dv=%b busy=%b done=%b fmt_err=%b, required all 0",
               o_tx_byte, o_tx_dv, o_busy, o_done, o_fmt_err);
    end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int    cyc;
    string s = "$GPGLL,1234.56,N,9876.54,E,122519,A*10";
    start_sentence(24'h123456, 1'b1, 24'h987654, 1'b1, 24'h122519, 1'b1);
    run_stream(1'b0, -1, 0, cyc);
    checks++;
    if (cyc != 40 || got_q.size() != 40) begin
      errors++;
      $display("FAIL basic_length: cycles=%0d bytes=%0d, required 40 40", cyc, got_q.size());
    end else begin
      for (int i = 0; i < 38; i++) begin
        checks++;
        if (got_q[i] !== s[i]) begin
          errors++;
          $display("FAIL basic_literal[%0d]: got %h, required %h", i, got_q[i], s[i]);
        end
      end
      checks++;
      if (got_q[38] !== 8'h0D || got_q[39] !== 8'h0A) begin
        errors++;
        $display("FAIL basic_crlf: got %h %h, required 0d 0a", got_q[38], got_q[39]);
      end
    end
    checks++;
    if (o_fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_fmt_err: got %b, required 0", o_fmt_err);
    end
    check_done_drop();
  endtask

  task automatic test_invalid();
    int cyc;
    start_sentence(24'h123456, 1'b1, 24'h987654, 1'b1, 24'h122519, 1'b0);
    run_stream(1'b0, -1, 0, cyc);
    checks++;
    if (got_q.size() != 40 || got_q[34] !== "V" || got_q[36] !== "0" || got_q[37] !== "7") begin
      errors++;
      $display("FAIL invalid_tail: size=%0d, required V*07 tail", got_q.size());
    end
    check_done_drop();
  endtask

  task automatic test_stall();
    int cyc;
    start_sentence(24'h123456, 1'b1, 24'h987654, 1'b1, 24'h122519, 1'b1);
    run_stream(1'b1, -1, 0, cyc);
    checks++;
    if (got_q.size() != 40 || cyc < 40) begin
      errors++;
      $display("FAIL stall_count: bytes=%0d cycles=%0d, required 40 bytes in >=40 cycles", got_q.size(), cyc);
    end
    check_done_drop();
  endtask

  task automatic test_fmt_err();
    int         cyc;
    logic [7:0] ck;
    string      s = "1204.56";
    start_sentence(24'h12A456, 1'b0, 24'h000159, 1'b0, 24'h235959, 1'b1);
    run_stream(1'b0, -1, 0, cyc);
    checks++;
    if (o_fmt_err !== 1'b1) begin
      errors++;
      $display("FAIL fmt_err_flag: got %b, required 1", o_fmt_err);
    end
    if (got_q.size() == 40) begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (got_q[7+i] !== s[i]) begin
          errors++;
          $display("FAIL fmt_err_lat[%0d]: got %h, required %h", i, got_q[7+i], s[i]);
        end
      end
      ck = 8'h00;
      for (int i = 1; i < 35; i++) ck = ck ^ got_q[i];
      checks++;
      if (got_q[36] !== m_hex(ck[7:4]) || got_q[37] !== m_hex(ck[3:0])) begin
        errors++;
        $display("FAIL fmt_err_checksum: got %h%h, required %h%h", got_q[36], got_q[37], m_hex(ck[7:4]), m_hex(ck[3:0]));
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (o_fmt_err !== 1'b1) begin
      errors++;
      $display("FAIL fmt_err_hold: got %b, required 1", o_fmt_err);
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    start_sentence(24'h051230, 1'b1, 24'h170000, 1'b0, 24'h000001, 1'b1);
    run_stream(1'b0, 10, 0, cyc);
    check_done_drop();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_tx_dv !== 1'b0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL start_ignored: dv=%b busy=%b, required 0 0", o_tx_dv, o_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_sentence(24'h123456, 1'b1, 24'h987654, 1'b1, 24'h122519, 1'b1);
    run_stream(1'b0, -1, 0, cyc);
    // Restart in the done cycle itself
    i_lat_bcd = 24'h999999; i_lat_n = 1'b0; i_lon_bcd = 24'h000000;
    i_lon_e = 1'b0; i_utc_bcd = 24'h010203; i_fix_valid = 1'b0; i_start = 1'b1;
    push_model(24'h999999, 1'b0, 24'h000000, 1'b0, 24'h010203, 1'b0);
    @(negedge clk);
    i_start = 1'b0;
    checks++;
    if (o_tx_dv !== 1'b1 || o_tx_byte !== 8'h24 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_start: dv=%b byte=%h done=%b, required 1 24 0", o_tx_dv, o_tx_byte, o_done);
    end
    run_stream(1'b0, -1, 0, cyc);
    checks++;
    if (cyc != 40) begin
      errors++;
      $display("FAIL back_to_back_cycles: got %0d, required 40", cyc);
    end
    check_done_drop();
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_sentence(24'h123456, 1'b1, 24'h987654, 1'b1, 24'h122519, 1'b1);
    run_stream(1'b0, -1, 20, cyc);
    rst = 1'b0;
    #1;
    checks++;
    if (o_tx_byte !== 8'h00 || o_tx_dv !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_fmt_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: byte=%h dv=%b busy=%b done=%b fmt_err=%b, required all 0",
               o_tx_byte, o_tx_dv, o_busy, o_done, o_fmt_err);
    end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_tx_dv !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: done=%b dv=%b, required 0 0", o_done, o_tx_dv);
    end
    rst = 1'b1;
    exp_q.delete();
    start_sentence(24'h123456, 1'b1, 24'h987654, 1'b1, 24'h122519, 1'b1);
    run_stream(1'b0, -1, 0, cyc);
    checks++;
    if (got_q.size() != 40) begin
      errors++;
      $display("FAIL reset_mid_resume: bytes=%0d, required 40", got_q.size());
    end
    check_done_drop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_stall();
    test_fmt_err();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_nmea_gpgll_tx
`default_nettype wire
